// File: rtl/axil_arbiter_2to1_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axil_arbiter_2to1_pkg
// Brief    : Shared state encoding, AXI response codes and round-robin pick.
// Revision : 1.0 - initial release
// ============================================================================
package axil_arbiter_2to1_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD_A = 3'd1,
        RD_D = 3'd2,
        WR_A = 3'd3,
        WR_B = 3'd4
    } state_t;

    localparam logic [1:0] c_resp_okay   = 2'b00;
    localparam logic [1:0] c_resp_exokay = 2'b01;
    localparam logic [1:0] c_resp_slverr = 2'b10;
    localparam logic [1:0] c_resp_decerr = 2'b11;

    // Returns the winning port index; with both requesting, the one not granted last wins.
    function automatic logic rr_pick(input logic [1:0] req, input logic last);
        logic w_port;
        if (req[0] && req[1]) begin
            w_port = ~last;
        end else if (req[1]) begin
            w_port = 1'b1;
        end else begin
            w_port = 1'b0;
        end
        return w_port;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axil_arbiter_2to1_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : axil_arbiter_2to1_rr_arb2
// Brief    : Two-request round-robin picker with a registered last grant.
// Revision : 1.0 - initial release
// ============================================================================
module axil_arbiter_2to1_rr_arb2
    import axil_arbiter_2to1_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_req,
    input  logic       i_accept,
    output logic       o_valid,
    output logic       o_port
);

    logic r_last;

    always_comb begin
        o_valid = |i_req;
        o_port  = rr_pick(i_req, r_last);
    end

    // Reset to port 1 so that port 0 wins the first contested arbitration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= 1'b1;
        end else if (i_accept && o_valid) begin
            r_last <= o_port;
        end
    end

endmodule
`default_nettype wire

// File: rtl/axil_arbiter_2to1.sv
`default_nettype none
// ============================================================================
// Module   : axil_arbiter_2to1
// Brief    : Two-requester AXI-lite arbiter onto one master, one txn in flight.
// Revision : 1.0 - initial release
// ============================================================================
module axil_arbiter_2to1
    import axil_arbiter_2to1_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH/8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // requester 0
    input  logic [ADDR_WIDTH-1:0] s0_axil_awaddr,
    input  logic [2:0]            s0_axil_awprot,
    input  logic                  s0_axil_awvalid,
    output logic                  s0_axil_awready,
    input  logic [DATA_WIDTH-1:0] s0_axil_wdata,
    input  logic [STRB_WIDTH-1:0] s0_axil_wstrb,
    input  logic                  s0_axil_wvalid,
    output logic                  s0_axil_wready,
    output logic [1:0]            s0_axil_bresp,
    output logic                  s0_axil_bvalid,
    input  logic                  s0_axil_bready,
    input  logic [ADDR_WIDTH-1:0] s0_axil_araddr,
    input  logic [2:0]            s0_axil_arprot,
    input  logic                  s0_axil_arvalid,
    output logic                  s0_axil_arready,
    output logic [DATA_WIDTH-1:0] s0_axil_rdata,
    output logic [1:0]            s0_axil_rresp,
    output logic                  s0_axil_rvalid,
    input  logic                  s0_axil_rready,
    // requester 1
    input  logic [ADDR_WIDTH-1:0] s1_axil_awaddr,
    input  logic [2:0]            s1_axil_awprot,
    input  logic                  s1_axil_awvalid,
    output logic                  s1_axil_awready,
    input  logic [DATA_WIDTH-1:0] s1_axil_wdata,
    input  logic [STRB_WIDTH-1:0] s1_axil_wstrb,
    input  logic                  s1_axil_wvalid,
    output logic                  s1_axil_wready,
    output logic [1:0]            s1_axil_bresp,
    output logic                  s1_axil_bvalid,
    input  logic                  s1_axil_bready,
    input  logic [ADDR_WIDTH-1:0] s1_axil_araddr,
    input  logic [2:0]            s1_axil_arprot,
    input  logic                  s1_axil_arvalid,
    output logic                  s1_axil_arready,
    output logic [DATA_WIDTH-1:0] s1_axil_rdata,
    output logic [1:0]            s1_axil_rresp,
    output logic                  s1_axil_rvalid,
    input  logic                  s1_axil_rready,
    // shared master
    output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
    output logic [2:0]            m_axil_awprot,
    output logic                  m_axil_awvalid,
    input  logic                  m_axil_awready,
    output logic [DATA_WIDTH-1:0] m_axil_wdata,
    output logic [STRB_WIDTH-1:0] m_axil_wstrb,
    output logic                  m_axil_wvalid,
    input  logic                  m_axil_wready,
    input  logic [1:0]            m_axil_bresp,
    input  logic                  m_axil_bvalid,
    output logic                  m_axil_bready,
    output logic [ADDR_WIDTH-1:0] m_axil_araddr,
    output logic [2:0]            m_axil_arprot,
    output logic                  m_axil_arvalid,
    input  logic                  m_axil_arready,
    input  logic [DATA_WIDTH-1:0] m_axil_rdata,
    input  logic [1:0]            m_axil_rresp,
    input  logic                  m_axil_rvalid,
    output logic                  m_axil_rready
);

    state_t     r_state;
    logic       r_grant;
    logic [1:0] r_wr_first;
    logic       r_aw_done;
    logic       r_w_done;

    logic [1:0] w_req;
    logic       w_arb_valid;
    logic       w_arb_port;
    logic       w_sel_rd;
    logic       w_sel_wr;
    logic       w_pick_write;
    logic       w_aw_fin;
    logic       w_w_fin;

    // A write only counts once both its address and data are offered.
    assign w_req = {s1_axil_arvalid | (s1_axil_awvalid & s1_axil_wvalid),
                    s0_axil_arvalid | (s0_axil_awvalid & s0_axil_wvalid)};

    axil_arbiter_2to1_rr_arb2 u_rr_arb2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_req    (w_req),
        .i_accept (r_state == IDLE),
        .o_valid  (w_arb_valid),
        .o_port   (w_arb_port)
    );

    always_comb begin
        w_sel_rd     = w_arb_port ? s1_axil_arvalid : s0_axil_arvalid;
        w_sel_wr     = w_arb_port ? (s1_axil_awvalid & s1_axil_wvalid)
                                  : (s0_axil_awvalid & s0_axil_wvalid);
        w_pick_write = w_sel_wr && (!w_sel_rd || r_wr_first[w_arb_port]);
        w_aw_fin     = r_aw_done | m_axil_awready;
        w_w_fin      = r_w_done  | m_axil_wready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_grant    <= 1'b0;
            r_wr_first <= 2'b11;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_arb_valid) begin
                        r_grant                <= w_arb_port;
                        r_wr_first[w_arb_port] <= ~r_wr_first[w_arb_port];
                        r_state                <= w_pick_write ? WR_A : RD_A;
                    end
                end
                RD_A: begin
                    if (m_axil_arready) begin
                        r_state <= RD_D;
                    end
                end
                RD_D: begin
                    if (m_axil_rvalid && m_axil_rready) begin
                        r_state <= IDLE;
                    end
                end
                WR_A: begin
                    if (w_aw_fin && w_w_fin) begin
                        r_state   <= WR_B;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                    end else begin
                        r_aw_done <= w_aw_fin;
                        r_w_done  <= w_w_fin;
                    end
                end
                WR_B: begin
                    if (m_axil_bvalid && m_axil_bready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Every output is decoded from registered state plus the opposite side's
    // handshake inputs, so nothing loops from a requester valid to its ready.
    always_comb begin
        m_axil_awaddr   = '0;
        m_axil_awprot   = '0;
        m_axil_awvalid  = 1'b0;
        m_axil_wdata    = '0;
        m_axil_wstrb    = '0;
        m_axil_wvalid   = 1'b0;
        m_axil_bready   = 1'b0;
        m_axil_araddr   = '0;
        m_axil_arprot   = '0;
        m_axil_arvalid  = 1'b0;
        m_axil_rready   = 1'b0;
        s0_axil_awready = 1'b0;
        s0_axil_wready  = 1'b0;
        s0_axil_bresp   = '0;
        s0_axil_bvalid  = 1'b0;
        s0_axil_arready = 1'b0;
        s0_axil_rdata   = '0;
        s0_axil_rresp   = '0;
        s0_axil_rvalid  = 1'b0;
        s1_axil_awready = 1'b0;
        s1_axil_wready  = 1'b0;
        s1_axil_bresp   = '0;
        s1_axil_bvalid  = 1'b0;
        s1_axil_arready = 1'b0;
        s1_axil_rdata   = '0;
        s1_axil_rresp   = '0;
        s1_axil_rvalid  = 1'b0;
        case (r_state)
            RD_A: begin
                m_axil_arvalid  = 1'b1;
                m_axil_araddr   = r_grant ? s1_axil_araddr : s0_axil_araddr;
                m_axil_arprot   = r_grant ? s1_axil_arprot : s0_axil_arprot;
                s0_axil_arready = ~r_grant & m_axil_arready;
                s1_axil_arready =  r_grant & m_axil_arready;
            end
            RD_D: begin
                m_axil_rready = r_grant ? s1_axil_rready : s0_axil_rready;
                if (r_grant) begin
                    s1_axil_rdata  = m_axil_rdata;
                    s1_axil_rresp  = m_axil_rresp;
                    s1_axil_rvalid = m_axil_rvalid;
                end else begin
                    s0_axil_rdata  = m_axil_rdata;
                    s0_axil_rresp  = m_axil_rresp;
                    s0_axil_rvalid = m_axil_rvalid;
                end
            end
            WR_A: begin
                m_axil_awvalid  = ~r_aw_done;
                m_axil_wvalid   = ~r_w_done;
                m_axil_awaddr   = r_grant ? s1_axil_awaddr : s0_axil_awaddr;
                m_axil_awprot   = r_grant ? s1_axil_awprot : s0_axil_awprot;
                m_axil_wdata    = r_grant ? s1_axil_wdata  : s0_axil_wdata;
                m_axil_wstrb    = r_grant ? s1_axil_wstrb  : s0_axil_wstrb;
                s0_axil_awready = ~r_grant & ~r_aw_done & m_axil_awready;
                s1_axil_awready =  r_grant & ~r_aw_done & m_axil_awready;
                s0_axil_wready  = ~r_grant & ~r_w_done  & m_axil_wready;
                s1_axil_wready  =  r_grant & ~r_w_done  & m_axil_wready;
            end
            WR_B: begin
                m_axil_bready = r_grant ? s1_axil_bready : s0_axil_bready;
                if (r_grant) begin
                    s1_axil_bresp  = m_axil_bresp;
                    s1_axil_bvalid = m_axil_bvalid;
                end else begin
                    s0_axil_bresp  = m_axil_bresp;
                    s0_axil_bvalid = m_axil_bvalid;
                end
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_axil_arbiter_2to1.sv
`default_nettype none
// ============================================================================
// Module   : tb_axil_arbiter_2to1
// Brief    : Directed self-checking bench for axil_arbiter_2to1.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axil_arbiter_2to1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] s0_axil_awaddr, s1_axil_awaddr, m_axil_awaddr;
    logic [2:0]  s0_axil_awprot, s1_axil_awprot, m_axil_awprot;
    logic        s0_axil_awvalid, s1_axil_awvalid, m_axil_awvalid;
    logic        s0_axil_awready, s1_axil_awready, m_axil_awready;
    logic [31:0] s0_axil_wdata, s1_axil_wdata, m_axil_wdata;
    logic [3:0]  s0_axil_wstrb, s1_axil_wstrb, m_axil_wstrb;
    logic        s0_axil_wvalid, s1_axil_wvalid, m_axil_wvalid;
    logic        s0_axil_wready, s1_axil_wready, m_axil_wready;
    logic [1:0]  s0_axil_bresp, s1_axil_bresp, m_axil_bresp;
    logic        s0_axil_bvalid, s1_axil_bvalid, m_axil_bvalid;
    logic        s0_axil_bready, s1_axil_bready, m_axil_bready;
    logic [31:0] s0_axil_araddr, s1_axil_araddr, m_axil_araddr;
    logic [2:0]  s0_axil_arprot, s1_axil_arprot, m_axil_arprot;
    logic        s0_axil_arvalid, s1_axil_arvalid, m_axil_arvalid;
    logic        s0_axil_arready, s1_axil_arready, m_axil_arready;
    logic [31:0] s0_axil_rdata, s1_axil_rdata, m_axil_rdata;
    logic [1:0]  s0_axil_rresp, s1_axil_rresp, m_axil_rresp;
    logic        s0_axil_rvalid, s1_axil_rvalid, m_axil_rvalid;
    logic        s0_axil_rready, s1_axil_rready, m_axil_rready;

    int checks = 0;
    int errors = 0;
    int ar_hs_cnt = 0;
    int s1_busy_cnt = 0;

    logic [40:0]  s1_out;
    logic [192:0] all_out;

    assign s1_out = {s1_axil_awready, s1_axil_wready, s1_axil_bresp, s1_axil_bvalid,
                     s1_axil_arready, s1_axil_rdata, s1_axil_rresp, s1_axil_rvalid};
    assign all_out = {s1_out,
                      s0_axil_awready, s0_axil_wready, s0_axil_bresp, s0_axil_bvalid,
                      s0_axil_arready, s0_axil_rdata, s0_axil_rresp, s0_axil_rvalid,
                      m_axil_awaddr, m_axil_awprot, m_axil_awvalid, m_axil_wdata,
                      m_axil_wstrb, m_axil_wvalid, m_axil_bready, m_axil_araddr,
                      m_axil_arprot, m_axil_arvalid, m_axil_rready};

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && m_axil_arvalid && m_axil_arready) ar_hs_cnt <= ar_hs_cnt + 1;
    end

    always @(negedge clk) begin
        if (s1_out !== '0) s1_busy_cnt <= s1_busy_cnt + 1;
    end

    axil_arbiter_2to1 #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STRB_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .s0_axil_awaddr(s0_axil_awaddr), .s0_axil_awprot(s0_axil_awprot),
        .s0_axil_awvalid(s0_axil_awvalid), .s0_axil_awready(s0_axil_awready),
        .s0_axil_wdata(s0_axil_wdata), .s0_axil_wstrb(s0_axil_wstrb),
        .s0_axil_wvalid(s0_axil_wvalid), .s0_axil_wready(s0_axil_wready),
        .s0_axil_bresp(s0_axil_bresp), .s0_axil_bvalid(s0_axil_bvalid),
        .s0_axil_bready(s0_axil_bready),
        .s0_axil_araddr(s0_axil_araddr), .s0_axil_arprot(s0_axil_arprot),
        .s0_axil_arvalid(s0_axil_arvalid), .s0_axil_arready(s0_axil_arready),
        .s0_axil_rdata(s0_axil_rdata), .s0_axil_rresp(s0_axil_rresp),
        .s0_axil_rvalid(s0_axil_rvalid), .s0_axil_rready(s0_axil_rready),
        .s1_axil_awaddr(s1_axil_awaddr), .s1_axil_awprot(s1_axil_awprot),
        .s1_axil_awvalid(s1_axil_awvalid), .s1_axil_awready(s1_axil_awready),
        .s1_axil_wdata(s1_axil_wdata), .s1_axil_wstrb(s1_axil_wstrb),
        .s1_axil_wvalid(s1_axil_wvalid), .s1_axil_wready(s1_axil_wready),
        .s1_axil_bresp(s1_axil_bresp), .s1_axil_bvalid(s1_axil_bvalid),
        .s1_axil_bready(s1_axil_bready),
        .s1_axil_araddr(s1_axil_araddr), .s1_axil_arprot(s1_axil_arprot),
        .s1_axil_arvalid(s1_axil_arvalid), .s1_axil_arready(s1_axil_arready),
        .s1_axil_rdata(s1_axil_rdata), .s1_axil_rresp(s1_axil_rresp),
        .s1_axil_rvalid(s1_axil_rvalid), .s1_axil_rready(s1_axil_rready),
        .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot),
        .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
        .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
        .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
        .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid),
        .m_axil_bready(m_axil_bready),
        .m_axil_araddr(m_axil_araddr), .m_axil_arprot(m_axil_arprot),
        .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
        .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp),
        .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready)
    );

    // Requesters always accept responses; everything else idles low.
    task automatic clear_inputs();
        s0_axil_awaddr = '0; s0_axil_awprot = '0; s0_axil_awvalid = 1'b0;
        s0_axil_wdata = '0; s0_axil_wstrb = '0; s0_axil_wvalid = 1'b0;
        s0_axil_araddr = '0; s0_axil_arprot = '0; s0_axil_arvalid = 1'b0;
        s0_axil_bready = 1'b1; s0_axil_rready = 1'b1;
        s1_axil_awaddr = '0; s1_axil_awprot = '0; s1_axil_awvalid = 1'b0;
        s1_axil_wdata = '0; s1_axil_wstrb = '0; s1_axil_wvalid = 1'b0;
        s1_axil_araddr = '0; s1_axil_arprot = '0; s1_axil_arvalid = 1'b0;
        s1_axil_bready = 1'b1; s1_axil_rready = 1'b1;
        m_axil_awready = 1'b0; m_axil_wready = 1'b0; m_axil_arready = 1'b0;
        m_axil_bresp = '0; m_axil_bvalid = 1'b0;
        m_axil_rdata = '0; m_axil_rresp = '0; m_axil_rvalid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
    endtask

    // Slave side of one read; reports which requester saw arready and rvalid.
    task automatic slave_read(input logic [31:0] data, input logic [1:0] resp,
                              output int wait_cyc, output int ar_port, output logic [31:0] addr,
                              output int r_port, output logic [31:0] rdata_seen,
                              output logic [1:0] rresp_seen, output bit tmo);
        wait_cyc = 0; ar_port = -1; r_port = -1; addr = '0;
        rdata_seen = '0; rresp_seen = '0; tmo = 1'b0;
        while (!m_axil_arvalid && wait_cyc < 8) begin
            @(posedge clk); #2;
            wait_cyc++;
        end
        if (!m_axil_arvalid) begin
            tmo = 1'b1;
        end else begin
            addr = m_axil_araddr;
            m_axil_arready = 1'b1;
            #1;
            if (s0_axil_arready && !s1_axil_arready) ar_port = 0;
            else if (s1_axil_arready && !s0_axil_arready) ar_port = 1;
            @(posedge clk); #1;
            m_axil_arready = 1'b0;
            m_axil_rvalid = 1'b1; m_axil_rdata = data; m_axil_rresp = resp;
            #1;
            if (s0_axil_rvalid && !s1_axil_rvalid) begin
                r_port = 0; rdata_seen = s0_axil_rdata; rresp_seen = s0_axil_rresp;
            end else if (s1_axil_rvalid && !s0_axil_rvalid) begin
                r_port = 1; rdata_seen = s1_axil_rdata; rresp_seen = s1_axil_rresp;
            end
            @(posedge clk); #1;
            m_axil_rvalid = 1'b0; m_axil_rdata = '0; m_axil_rresp = '0;
            #1;
        end
    endtask

    // Slave side of one write: awready held from cycle aw_dly, wready from w_dly.
    task automatic slave_write(input int aw_dly, input int w_dly, input logic [1:0] resp,
                               output int port, output logic [31:0] awaddr,
                               output logic [31:0] wdata, output logic [3:0] wstrb,
                               output int aw_pulses, output int w_pulses, output int wa_cycles,
                               output bit b_early, output int b_port,
                               output logic [1:0] bresp_seen, output bit tmo);
        int  wait_cyc;
        int  cyc;
        bit  aw_got, w_got;
        logic a0, a1, w0, w1;
        wait_cyc = 0; port = -1; awaddr = '0; wdata = '0; wstrb = '0;
        aw_pulses = 0; w_pulses = 0; wa_cycles = 0; b_early = 1'b0;
        b_port = -1; bresp_seen = '0; tmo = 1'b0;
        while (!m_axil_awvalid && wait_cyc < 8) begin
            @(posedge clk); #2;
            wait_cyc++;
        end
        if (!m_axil_awvalid) begin
            tmo = 1'b1;
        end else begin
            awaddr = m_axil_awaddr; wdata = m_axil_wdata; wstrb = m_axil_wstrb;
            aw_got = 1'b0; w_got = 1'b0; cyc = 0;
            while (!(aw_got && w_got) && cyc < 12) begin
                m_axil_awready = (cyc >= aw_dly);
                m_axil_wready  = (cyc >= w_dly);
                #1;
                a0 = s0_axil_awready; a1 = s1_axil_awready;
                w0 = s0_axil_wready;  w1 = s1_axil_wready;
                if (a0 || a1) aw_pulses++;
                if (w0 || w1) w_pulses++;
                if (a0 || w0) port = 0;
                if (a1 || w1) port = 1;
                if (m_axil_bready) b_early = 1'b1;
                if (m_axil_awvalid && m_axil_awready) aw_got = 1'b1;
                if (m_axil_wvalid && m_axil_wready) w_got = 1'b1;
                @(posedge clk); #1;
                m_axil_awready = 1'b0; m_axil_wready = 1'b0;
                if (a0) s0_axil_awvalid = 1'b0;
                if (a1) s1_axil_awvalid = 1'b0;
                if (w0) s0_axil_wvalid = 1'b0;
                if (w1) s1_axil_wvalid = 1'b0;
                cyc++;
            end
            wa_cycles = cyc;
            if (!(aw_got && w_got)) tmo = 1'b1;
            m_axil_bvalid = 1'b1; m_axil_bresp = resp;
            #1;
            if (s0_axil_bvalid && !s1_axil_bvalid) begin
                b_port = 0; bresp_seen = s0_axil_bresp;
            end else if (s1_axil_bvalid && !s0_axil_bvalid) begin
                b_port = 1; bresp_seen = s1_axil_bresp;
            end else if (s0_axil_bvalid && s1_axil_bvalid) begin
                b_port = 2;
            end
            @(posedge clk); #1;
            m_axil_bvalid = 1'b0; m_axil_bresp = '0;
            #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        s0_axil_arvalid = 1'b1; s1_axil_arvalid = 1'b1;
        s0_axil_awvalid = 1'b1; s0_axil_wvalid = 1'b1;
        m_axil_arready = 1'b1; m_axil_awready = 1'b1; m_axil_wready = 1'b1;
        m_axil_rvalid = 1'b1; m_axil_rdata = 32'hFFFF_FFFF; m_axil_bvalid = 1'b1;
        m_axil_bresp = 2'b11; m_axil_rresp = 2'b11;
        repeat (2) @(posedge clk); #2;
        checks++;
        if (all_out !== '0) begin
            errors++; $display("FAIL reset_outputs: got %h expected 0", all_out);
        end
        @(posedge clk); #1;
        rst_n = 1'b1; s1_axil_arvalid = 1'b0; s0_axil_awvalid = 1'b0; s0_axil_wvalid = 1'b0;
        #1;
        checks++;
        if (m_axil_arvalid !== 1'b0) begin
            errors++; $display("FAIL idle_arvalid: got %b expected 0", m_axil_arvalid);
        end
        checks++;
        if (all_out !== '0) begin
            errors++; $display("FAIL idle_outputs: got %h expected 0", all_out);
        end
        @(posedge clk); #2;
        checks++;
        if ({m_axil_arvalid, s0_axil_arready, s1_axil_arready} !== 3'b110) begin
            errors++; $display("FAIL first_grant: got %b expected 110",
                               {m_axil_arvalid, s0_axil_arready, s1_axil_arready});
        end
        do_reset();
    endtask

    task automatic test_single_read();
        int wc, ap, rp; logic [31:0] ad, rd; logic [1:0] rr; bit tmo;
        int hs0, busy0;
        do_reset();
        hs0 = ar_hs_cnt; busy0 = s1_busy_cnt;
        s0_axil_araddr = 32'h0000_1000; s0_axil_arprot = 3'b010; s0_axil_arvalid = 1'b1;
        slave_read(32'hDEAD_BEEF, 2'b00, wc, ap, ad, rp, rd, rr, tmo);
        s0_axil_arvalid = 1'b0;
        @(posedge clk); #2;
        checks++;
        if (tmo || ap !== 0 || ad !== 32'h0000_1000) begin
            errors++; $display("FAIL single_ar: got tmo=%0d port=%0d addr=%h expected 0/0/00001000", tmo, ap, ad);
        end
        checks++;
        if (rp !== 0 || rd !== 32'hDEAD_BEEF || rr !== 2'b00) begin
            errors++; $display("FAIL single_r: got port=%0d data=%h resp=%b expected 0/deadbeef/00", rp, rd, rr);
        end
        checks++;
        if (ar_hs_cnt - hs0 !== 1) begin
            errors++; $display("FAIL single_ar_count: got %0d expected 1", ar_hs_cnt - hs0);
        end
        checks++;
        if (s1_busy_cnt - busy0 !== 0) begin
            errors++; $display("FAIL single_s1_quiet: got %0d active cycles expected 0", s1_busy_cnt - busy0);
        end
        checks++;
        if (wc !== 1) begin
            errors++; $display("FAIL single_latency: got %0d idle cycles expected 1", wc);
        end
    endtask

    task automatic test_round_robin();
        int wc, ap, rp, exp_p; logic [31:0] ad, rd, exp_a; logic [1:0] rr; bit tmo;
        do_reset();
        s0_axil_araddr = 32'h0000_0100; s0_axil_arvalid = 1'b1;
        s1_axil_araddr = 32'h0000_0200; s1_axil_arvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            slave_read(32'hA000_0000 + i, 2'b00, wc, ap, ad, rp, rd, rr, tmo);
            exp_p = i % 2;
            exp_a = (exp_p == 1) ? 32'h0000_0200 : 32'h0000_0100;
            checks++;
            if (tmo || ap !== exp_p || ad !== exp_a) begin
                errors++; $display("FAIL rr_grant[%0d]: got tmo=%0d port=%0d addr=%h expected port %0d addr %h",
                                   i, tmo, ap, ad, exp_p, exp_a);
            end
            checks++;
            if (rp !== exp_p || rd !== 32'hA000_0000 + i) begin
                errors++; $display("FAIL rr_rdata[%0d]: got port=%0d data=%h expected port %0d data %h",
                                   i, rp, rd, exp_p, 32'hA000_0000 + i);
            end
            checks++;
            if (wc !== 1) begin
                errors++; $display("FAIL rr_back_to_back[%0d]: got %0d idle cycles expected 1", i, wc);
            end
        end
        s0_axil_arvalid = 1'b0; s1_axil_arvalid = 1'b0;
        @(posedge clk); #2;
    endtask

    task automatic test_toggle();
        int exp_port[4] = '{0, 1, 0, 1};
        bit exp_wr[4]   = '{1'b1, 1'b1, 1'b0, 1'b0};
        int wc, ap, rp, pt, awp, wp, wac, bp; logic [31:0] ad, rd, aa, wd; logic [3:0] ws;
        logic [1:0] rr, br; bit tmo, be;
        do_reset();
        s0_axil_awaddr = 32'h30; s0_axil_wdata = 32'h1111; s0_axil_wstrb = 4'h3;
        s0_axil_araddr = 32'h50;
        s1_axil_awaddr = 32'h20; s1_axil_wdata = 32'h55AA; s1_axil_wstrb = 4'hF;
        s1_axil_araddr = 32'h40;
        s0_axil_awvalid = 1'b1; s0_axil_wvalid = 1'b1; s0_axil_arvalid = 1'b1;
        s1_axil_awvalid = 1'b1; s1_axil_wvalid = 1'b1; s1_axil_arvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (exp_wr[i]) begin
                slave_write(0, 0, 2'b00, pt, aa, wd, ws, awp, wp, wac, be, bp, br, tmo);
                s0_axil_awvalid = 1'b1; s0_axil_wvalid = 1'b1;
                s1_axil_awvalid = 1'b1; s1_axil_wvalid = 1'b1;
                checks++;
                if (tmo || pt !== exp_port[i] || bp !== exp_port[i]) begin
                    errors++; $display("FAIL toggle_wr_port[%0d]: got tmo=%0d port=%0d bport=%0d expected %0d",
                                       i, tmo, pt, bp, exp_port[i]);
                end
                checks++;
                if (exp_port[i] == 1 && (aa !== 32'h20 || wd !== 32'h55AA || ws !== 4'hF)) begin
                    errors++; $display("FAIL toggle_wr_s1_fields: got %h/%h/%h expected 20/55aa/f", aa, wd, ws);
                end else if (exp_port[i] == 0 && (aa !== 32'h30 || wd !== 32'h1111 || ws !== 4'h3)) begin
                    errors++; $display("FAIL toggle_wr_s0_fields: got %h/%h/%h expected 30/1111/3", aa, wd, ws);
                end
            end else begin
                slave_read(32'h0BAD_0000 + i, 2'b00, wc, ap, ad, rp, rd, rr, tmo);
                checks++;
                if (tmo || ap !== exp_port[i] || ad !== ((exp_port[i] == 1) ? 32'h40 : 32'h50)) begin
                    errors++; $display("FAIL toggle_rd[%0d]: got tmo=%0d port=%0d addr=%h expected port %0d",
                                       i, tmo, ap, ad, exp_port[i]);
                end
            end
        end
        clear_inputs();
        @(posedge clk); #2;
    endtask

    task automatic test_write_latency();
        int pt, awp, wp, wac, bp; logic [31:0] aa, wd; logic [3:0] ws; logic [1:0] br; bit tmo, be;
        do_reset();
        s0_axil_awaddr = 32'h80; s0_axil_wdata = 32'hCAFE_F00D; s0_axil_wstrb = 4'hC;
        s0_axil_awvalid = 1'b1; s0_axil_wvalid = 1'b1;
        slave_write(1, 4, 2'b00, pt, aa, wd, ws, awp, wp, wac, be, bp, br, tmo);
        checks++;
        if (tmo || awp !== 1 || wp !== 1) begin
            errors++; $display("FAIL split_pulses: got tmo=%0d aw=%0d w=%0d expected 0/1/1", tmo, awp, wp);
        end
        checks++;
        if (wac !== 5 || be !== 1'b0) begin
            errors++; $display("FAIL split_b_timing: got cycles=%0d early_b=%0d expected 5/0", wac, be);
        end
        checks++;
        if (bp !== 0 || br !== 2'b00 || aa !== 32'h80 || wd !== 32'hCAFE_F00D) begin
            errors++; $display("FAIL split_b_route: got bport=%0d resp=%b addr=%h data=%h expected 0/00/80/cafef00d",
                               bp, br, aa, wd);
        end
    endtask

    task automatic test_error_resp();
        int pt, awp, wp, wac, bp, wc, ap, rp; logic [31:0] aa, wd, ad, rd; logic [3:0] ws;
        logic [1:0] br, rr; bit tmo, be;
        do_reset();
        s1_axil_awaddr = 32'h90; s1_axil_wdata = 32'h1; s1_axil_wstrb = 4'h1;
        s1_axil_awvalid = 1'b1; s1_axil_wvalid = 1'b1;
        slave_write(0, 2, 2'b10, pt, aa, wd, ws, awp, wp, wac, be, bp, br, tmo);
        checks++;
        if (tmo || bp !== 1 || br !== 2'b10) begin
            errors++; $display("FAIL slverr_b: got tmo=%0d bport=%0d resp=%b expected 0/1/10", tmo, bp, br);
        end
        s0_axil_araddr = 32'hA0; s0_axil_arvalid = 1'b1;
        slave_read(32'h0, 2'b11, wc, ap, ad, rp, rd, rr, tmo);
        s0_axil_arvalid = 1'b0;
        checks++;
        if (tmo || rp !== 0 || rr !== 2'b11) begin
            errors++; $display("FAIL decerr_r: got tmo=%0d rport=%0d resp=%b expected 0/0/11", tmo, rp, rr);
        end
        @(posedge clk); #2;
    endtask

    task automatic test_reset_mid();
        int wc, ap, rp; logic [31:0] ad, rd; logic [1:0] rr; bit tmo;
        do_reset();
        s0_axil_araddr = 32'h300; s0_axil_arvalid = 1'b1;
        @(posedge clk); #2;
        m_axil_arready = 1'b1;
        @(posedge clk); #1;
        m_axil_arready = 1'b0; s0_axil_arvalid = 1'b0;
        m_axil_rvalid = 1'b1; m_axil_rdata = 32'h1234;
        #1;
        checks++;
        if (s0_axil_rvalid !== 1'b1 || s0_axil_rdata !== 32'h1234) begin
            errors++; $display("FAIL mid_rd_d: got rvalid=%b data=%h expected 1/00001234", s0_axil_rvalid, s0_axil_rdata);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (all_out !== '0) begin
            errors++; $display("FAIL async_reset_outputs: got %h expected 0", all_out);
        end
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1; m_axil_rvalid = 1'b0; m_axil_rdata = '0;
        s0_axil_arvalid = 1'b1; s1_axil_araddr = 32'h400; s1_axil_arvalid = 1'b1;
        #1;
        slave_read(32'h5, 2'b00, wc, ap, ad, rp, rd, rr, tmo);
        s0_axil_arvalid = 1'b0; s1_axil_arvalid = 1'b0;
        checks++;
        if (tmo || ap !== 0 || ad !== 32'h300) begin
            errors++; $display("FAIL post_reset_grant: got tmo=%0d port=%0d addr=%h expected 0/0/300", tmo, ap, ad);
        end
        @(posedge clk); #2;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_toggle();
        test_write_latency();
        test_error_resp();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
